// File: rtl/ganador_nxn_if.sv
// Request/result bundle between the game controller and the N x N win detector.
interface ganador_nxn_if #(
   parameter int N  = 3,
   parameter int CW = $clog2(N)
);
   logic              start;
   logic [2*N*N-1:0]  board;
   logic              busy;
   logic              done;
   logic              winner;
   logic [1:0]        winner_player;
   logic              draw;
   logic [CW-1:0]     win_row;
   logic [CW-1:0]     win_col;
   logic [1:0]        win_dir;

   modport master (
      output start, board,
      input  busy, done, winner, winner_player, draw, win_row, win_col, win_dir
   );

   modport slave (
      input  start, board,
      output busy, done, winner, winner_player, draw, win_row, win_col, win_dir
   );
endinterface

// File: rtl/ganador_nxn.sv
// Sequential K-in-a-row win detector: snapshots the board on start, then tests one
// cell per cycle in row-major order along four directions, stopping at the first run.
module ganador_nxn #(
   parameter int N  = 3,
   parameter int K  = 3,
   parameter int IW = $clog2(N*N),
   parameter int CW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   ganador_nxn_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [2*N*N-1:0]  r_snap;
   logic [IW-1:0]     r_idx;
   logic [CW-1:0]     r_row;
   logic [CW-1:0]     r_col;
   logic              r_any_empty;
   logic              r_winner;
   logic [1:0]        r_player;
   logic              r_draw;
   logic [CW-1:0]     r_win_row;
   logic [CW-1:0]     r_win_col;
   logic [1:0]        r_win_dir;
   logic [1:0]        w_val;
   logic              w_empty;
   logic              w_last;
   logic              w_hit;
   logic [1:0]        w_dir;

   // Off-board coordinates read as empty, so a run that would leave the board
   // (or wrap into the next row) can never match a player value.
   function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] s, input int rr, input int cc);
      if (rr < 0 || rr >= N || cc < 0 || cc >= N) return 2'b00;
      return s[2*(rr*N+cc) +: 2];
   endfunction

   function automatic logic run_ok(input logic [2*N*N-1:0] s, input int rr, input int cc,
                                   input int dr, input int dc, input logic [1:0] v);
      logic ok;
      ok = (v == 2'b01) || (v == 2'b10);
      for (int unsigned j = 1; j < K; j++) begin
         if (cell_at(s, rr + int'(j)*dr, cc + int'(j)*dc) != v) ok = 1'b0;
      end
      return ok;
   endfunction

   always_comb begin
      w_val   = cell_at(r_snap, int'(r_row), int'(r_col));
      w_empty = (w_val == 2'b00) || (w_val == 2'b11);
      w_last  = (r_idx == IW'(N*N-1));
      w_hit   = 1'b0;
      w_dir   = 2'b00;
      // Lowest direction code wins: horizontal, vertical, diagonal, anti-diagonal.
      for (int unsigned d = 0; d < 4; d++) begin
         if (!w_hit && run_ok(r_snap, int'(r_row), int'(r_col),
                              (d == 0) ? 0 : 1,
                              (d == 1) ? 0 : ((d == 3) ? -1 : 1), w_val)) begin
            w_hit = 1'b1;
            w_dir = d[1:0];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_SCAN;
         S_SCAN:  if (w_hit || w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap      <= '0;
         r_idx       <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_any_empty <= 1'b0;
         r_winner    <= 1'b0;
         r_player    <= 2'b00;
         r_draw      <= 1'b0;
         r_win_row   <= '0;
         r_win_col   <= '0;
         r_win_dir   <= 2'b00;
      end else if (r_state == S_IDLE && bus.start) begin
         r_snap      <= bus.board;
         r_idx       <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_any_empty <= 1'b0;
      end else if (r_state == S_SCAN) begin
         if (w_hit) begin
            r_winner  <= 1'b1;
            r_player  <= w_val;
            r_draw    <= 1'b0;
            r_win_row <= r_row;
            r_win_col <= r_col;
            r_win_dir <= w_dir;
         end else if (w_last) begin
            r_winner  <= 1'b0;
            r_player  <= 2'b00;
            r_draw    <= !(r_any_empty || w_empty);
            r_win_row <= '0;
            r_win_col <= '0;
            r_win_dir <= 2'b00;
         end else begin
            r_idx       <= r_idx + 1'b1;
            r_any_empty <= r_any_empty || w_empty;
            if (r_col == CW'(N-1)) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   assign bus.busy          = (r_state == S_SCAN);
   assign bus.done          = (r_state == S_DONE);
   assign bus.winner        = r_winner;
   assign bus.winner_player = r_player;
   assign bus.draw          = r_draw;
   assign bus.win_row       = r_win_row;
   assign bus.win_col       = r_win_col;
   assign bus.win_dir       = r_win_dir;

endmodule

// File: tb/tb_ganador_nxn.sv
// Directed bench for ganador_nxn: 3x3/K=3 and 5x5/K=4 instances with hand-computed results.
module tb_ganador_nxn;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   ganador_nxn_if #(.N(3), .CW(2)) b3 ();
   ganador_nxn_if #(.N(5), .CW(3)) b5 ();

   ganador_nxn #(.N(3), .K(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
   ganador_nxn #(.N(5), .K(4)) u5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

   logic [17:0] B_ROW, B_ANTI, B_DRAW, B_TOP;

   // Start pulse at the current negedge (cycle 0); returns at the done cycle or budget.
   task automatic pulse3(input logic [17:0] b, output int cyc, output bit busy_ok);
      b3.board = b; b3.start = 1'b1;
      @(negedge clk); b3.start = 1'b0;
      cyc = 1; busy_ok = 1'b1;
      while (b3.done !== 1'b1 && cyc < 60) begin
         if (b3.busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk); cyc++;
      end
   endtask

   task automatic pulse5(input logic [49:0] b, output int cyc);
      b5.board = b; b5.start = 1'b1;
      @(negedge clk); b5.start = 1'b0;
      cyc = 1;
      while (b5.done !== 1'b1 && cyc < 60) begin
         @(negedge clk); cyc++;
      end
   endtask

   task automatic test_reset;
      total++; if (b3.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", b3.busy); end
      total++; if (b3.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", b3.done); end
      total++; if (b3.winner !== 1'b0) begin bad++; $display("FAIL rst_winner got=%0b exp=0", b3.winner); end
      total++; if (b3.winner_player !== 2'b00) begin bad++; $display("FAIL rst_player got=%0b exp=00", b3.winner_player); end
      total++; if (b3.draw !== 1'b0) begin bad++; $display("FAIL rst_draw got=%0b exp=0", b3.draw); end
      total++; if ({b3.win_row, b3.win_col, b3.win_dir} !== 6'd0) begin bad++;
         $display("FAIL rst_pos got=%0h exp=0", {b3.win_row, b3.win_col, b3.win_dir}); end
      total++; if ({b5.busy, b5.done, b5.winner} !== 3'b000) begin bad++;
         $display("FAIL rst_n5 got=%0b exp=000", {b5.busy, b5.done, b5.winner}); end
   endtask

   task automatic test_row_win;
      int cyc; bit bok;
      pulse3(B_ROW, cyc, bok);
      total++; if (cyc !== 5) begin bad++; $display("FAIL row_cycle got=%0d exp=5", cyc); end
      total++; if (bok !== 1'b1) begin bad++; $display("FAIL row_busy got=%0b exp=1", bok); end
      total++; if (b3.busy !== 1'b0) begin bad++; $display("FAIL row_busy_at_done got=%0b exp=0", b3.busy); end
      total++; if ({b3.winner, b3.winner_player, b3.draw} !== 4'b1010) begin bad++;
         $display("FAIL row_result got=%0b exp=1010", {b3.winner, b3.winner_player, b3.draw}); end
      total++; if ({b3.win_row, b3.win_col, b3.win_dir} !== {2'd1, 2'd0, 2'b00}) begin bad++;
         $display("FAIL row_pos got=%0h exp=%0h", {b3.win_row, b3.win_col, b3.win_dir}, {2'd1, 2'd0, 2'b00}); end
      @(negedge clk);
      total++; if ({b3.done, b3.winner, b3.win_row} !== {1'b0, 1'b1, 2'd1}) begin bad++;
         $display("FAIL row_hold got=%0b exp=0101", {b3.done, b3.winner, b3.win_row}); end
   endtask

   task automatic test_anti_diag;
      int cyc; bit bok;
      pulse3(B_ANTI, cyc, bok);
      total++; if (cyc !== 4) begin bad++; $display("FAIL anti_cycle got=%0d exp=4", cyc); end
      total++; if ({b3.winner, b3.winner_player} !== 3'b110) begin bad++;
         $display("FAIL anti_player got=%0b exp=110", {b3.winner, b3.winner_player}); end
      total++; if ({b3.win_row, b3.win_col, b3.win_dir} !== {2'd0, 2'd2, 2'b11}) begin bad++;
         $display("FAIL anti_pos got=%0h exp=%0h", {b3.win_row, b3.win_col, b3.win_dir}, {2'd0, 2'd2, 2'b11}); end
      @(negedge clk);
   endtask

   task automatic test_draw;
      int cyc; bit bok; logic [17:0] b;
      pulse3(B_DRAW, cyc, bok);
      total++; if (cyc !== 10) begin bad++; $display("FAIL draw_cycle got=%0d exp=10", cyc); end
      total++; if (bok !== 1'b1) begin bad++; $display("FAIL draw_busy got=%0b exp=1", bok); end
      total++; if ({b3.winner, b3.winner_player, b3.draw} !== 4'b0001) begin bad++;
         $display("FAIL draw_result got=%0b exp=0001", {b3.winner, b3.winner_player, b3.draw}); end
      total++; if ({b3.win_row, b3.win_col, b3.win_dir} !== 6'd0) begin bad++;
         $display("FAIL draw_pos got=%0h exp=0", {b3.win_row, b3.win_col, b3.win_dir}); end
      @(negedge clk);
      b = B_DRAW; b[17:16] = 2'b11;
      pulse3(b, cyc, bok);
      total++; if (cyc !== 10) begin bad++; $display("FAIL nodraw_cycle got=%0d exp=10", cyc); end
      total++; if ({b3.winner, b3.winner_player, b3.draw} !== 4'b0000) begin bad++;
         $display("FAIL nodraw_result got=%0b exp=0000", {b3.winner, b3.winner_player, b3.draw}); end
      @(negedge clk);
   endtask

   task automatic test_priority_n5;
      int cyc; logic [49:0] b;
      b = '0;
      for (int i = 0; i < 4; i++) begin b[2*i +: 2] = 2'b01; b[2*(5*i) +: 2] = 2'b01; end
      pulse5(b, cyc);
      total++; if (cyc !== 2) begin bad++; $display("FAIL prio_cycle got=%0d exp=2", cyc); end
      total++; if ({b5.winner, b5.winner_player, b5.win_dir} !== 5'b10100) begin bad++;
         $display("FAIL prio_dir got=%0b exp=10100", {b5.winner, b5.winner_player, b5.win_dir}); end
      @(negedge clk);
      b = '0;
      for (int i = 0; i < 4; i++) b[2*(5*i) +: 2] = 2'b01;
      pulse5(b, cyc);
      total++; if (cyc !== 2) begin bad++; $display("FAIL col_cycle got=%0d exp=2", cyc); end
      total++; if ({b5.winner_player, b5.win_row, b5.win_col, b5.win_dir} !== {2'b01, 3'd0, 3'd0, 2'b01}) begin bad++;
         $display("FAIL col_result got=%0h exp=%0h", {b5.winner_player, b5.win_row, b5.win_col, b5.win_dir},
                  {2'b01, 3'd0, 3'd0, 2'b01}); end
      @(negedge clk);
      // Diagonal ending in the bottom-right corner.
      b = '0;
      for (int i = 0; i < 4; i++) b[2*(6 + 6*i) +: 2] = 2'b10;
      pulse5(b, cyc);
      total++; if (cyc !== 8) begin bad++; $display("FAIL diag_cycle got=%0d exp=8", cyc); end
      total++; if ({b5.winner_player, b5.win_row, b5.win_col, b5.win_dir} !== {2'b10, 3'd1, 3'd1, 2'b10}) begin bad++;
         $display("FAIL diag_result got=%0h exp=%0h", {b5.winner_player, b5.win_row, b5.win_col, b5.win_dir},
                  {2'b10, 3'd1, 3'd1, 2'b10}); end
      @(negedge clk);
      // Four in a row only by wrapping from row 0 into row 1: not a win.
      b = '0;
      for (int i = 3; i < 7; i++) b[2*i +: 2] = 2'b01;
      pulse5(b, cyc);
      total++; if (cyc !== 26) begin bad++; $display("FAIL wrap_cycle got=%0d exp=26", cyc); end
      total++; if ({b5.winner, b5.draw} !== 2'b00) begin bad++;
         $display("FAIL wrap_result got=%0b exp=00", {b5.winner, b5.draw}); end
      @(negedge clk);
   endtask

   task automatic test_ignore;
      int cyc; int ndone;
      b3.board = B_ROW; b3.start = 1'b1;
      @(negedge clk); b3.start = 1'b0;                // cycle 1
      @(negedge clk); b3.board = B_TOP;               // cycle 2
      @(negedge clk); b3.start = 1'b1;                // cycle 3
      @(negedge clk); b3.start = 1'b0; cyc = 4;       // cycle 4
      while (b3.done !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
      total++; if (cyc !== 5) begin bad++; $display("FAIL ign_cycle got=%0d exp=5", cyc); end
      total++; if ({b3.winner_player, b3.win_row, b3.win_dir} !== {2'b01, 2'd1, 2'b00}) begin bad++;
         $display("FAIL ign_result got=%0h exp=%0h", {b3.winner_player, b3.win_row, b3.win_dir}, {2'b01, 2'd1, 2'b00}); end
      ndone = 0;
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (b3.done === 1'b1) ndone++; end
      total++; if (ndone !== 0) begin bad++; $display("FAIL ign_extra_done got=%0d exp=0", ndone); end
   endtask

   task automatic test_back_to_back;
      int cyc; bit bok;
      pulse3(B_ANTI, cyc, bok);
      total++; if (cyc !== 4) begin bad++; $display("FAIL b2b_first_cycle got=%0d exp=4", cyc); end
      b3.board = B_ROW; b3.start = 1'b1;              // held across DONE into IDLE
      @(negedge clk);
      total++; if (b3.busy !== 1'b0) begin bad++; $display("FAIL b2b_start_in_done got=%0b exp=0", b3.busy); end
      @(negedge clk); b3.start = 1'b0; cyc = 1;
      total++; if (b3.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%0b exp=1", b3.busy); end
      while (b3.done !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
      total++; if (cyc !== 5) begin bad++; $display("FAIL b2b_cycle got=%0d exp=5", cyc); end
      total++; if ({b3.winner_player, b3.win_row, b3.win_col} !== {2'b01, 2'd1, 2'd0}) begin bad++;
         $display("FAIL b2b_result got=%0h exp=%0h", {b3.winner_player, b3.win_row, b3.win_col}, {2'b01, 2'd1, 2'd0}); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int cyc; int ndone; bit bok;
      b3.board = B_DRAW; b3.start = 1'b1;
      @(negedge clk); b3.start = 1'b0;
      repeat (3) @(negedge clk);                      // cycle 4
      total++; if (b3.busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%0b exp=1", b3.busy); end
      rst_n = 1'b0; #1;
      total++; if ({b3.busy, b3.done, b3.winner, b3.winner_player, b3.draw} !== 6'd0) begin bad++;
         $display("FAIL rmid_flags got=%0b exp=0", {b3.busy, b3.done, b3.winner, b3.winner_player, b3.draw}); end
      total++; if ({b3.win_row, b3.win_col, b3.win_dir} !== 6'd0) begin bad++;
         $display("FAIL rmid_pos got=%0h exp=0", {b3.win_row, b3.win_col, b3.win_dir}); end
      @(negedge clk); rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (b3.done === 1'b1) ndone++; end
      total++; if (ndone !== 0) begin bad++; $display("FAIL rmid_done got=%0d exp=0", ndone); end
      pulse3(B_ANTI, cyc, bok);
      total++; if (cyc !== 4) begin bad++; $display("FAIL rmid_restart_cycle got=%0d exp=4", cyc); end
      total++; if ({b3.winner_player, b3.win_col, b3.win_dir} !== {2'b10, 2'd2, 2'b11}) begin bad++;
         $display("FAIL rmid_restart got=%0h exp=%0h", {b3.winner_player, b3.win_col, b3.win_dir}, {2'b10, 2'd2, 2'b11}); end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      B_ROW  = 18'b00_00_00_01_01_01_00_00_00;        // cells 3,4,5 = 01
      B_ANTI = 18'b00_00_10_00_10_00_10_01_01;        // cells 2,4,6 = 10; 0,1 = 01
      B_DRAW = 18'b01_01_10_10_10_01_01_10_01;        // full board, no line
      B_TOP  = 18'b00_00_00_00_00_00_10_10_10;        // cells 0,1,2 = 10
      b3.start = 1'b0; b3.board = '0;
      b5.start = 1'b0; b5.board = '0;
      repeat (3) @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      @(negedge clk);
      test_reset;
      test_row_win;
      test_anti_diag;
      test_draw;
      test_priority_n5;
      test_ignore;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ganador_nxn.md
# ganador_nxn

Sequential win detector for generalised N×N, K-in-a-row board games; the parametrised successor to the 3×3 combinational winner check. On a start pulse it snapshots the whole board, then scans cells in row-major order, one per cycle, testing four line directions from each cell. It stops at the first K-run found, or at the end of the board, and then reports the winner, the winning player, the line's start cell and direction, or a draw. It sits between the board register file and the game-control FSM.

## Interface
- N, 3: board side length; N ≥ 3.
- K, 3: run length required to win; 2 ≤ K ≤ N.
- IW, clog2(N*N): width of the internal scan index.
- CW, clog2(N): width of the row and column outputs.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to evaluate `board`; ignored while busy.
- board  in  2*N*N  flattened board; cell i = r*N+c occupies bits [2i+1:2i]. Encoding: 00 empty, 01 player 1, 10 player 2, 11 treated as empty.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the results are valid.
- winner  out  1  a K-run was found.
- winner_player  out  2  01 or 10 for the winning player; 00 if there is no winner.
- draw  out  1  no winner and no empty cell (00 or 11) on the board.
- win_row, win_col  out  CW each  start cell of the winning run; 0 if there is no winner.
- win_dir  out  2  00 horizontal (c+j), 01 vertical (r+j), 10 diagonal (r+j, c+j), 11 anti-diagonal (r+j, c−j).

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 latches `board` into a snapshot register, clears idx to 0, and moves to SCAN.
  - The result outputs keep their previous values until the next done.
- SCAN, each cycle, evaluates cell idx = (r,c) against the snapshot. Direction d qualifies when:
  - all K cells along d fit on the board: c+K−1<N for horizontal, r+K−1<N for vertical, both for diagonal, r+K−1<N and c≥K−1 for anti-diagonal;
  - all K cells hold the same value, and that value is 01 or 10.
- Direction priority at one cell: horizontal > vertical > diagonal > anti-diagonal.
- When a direction qualifies:
  - register winner=1, winner_player=the cell value, win_row=r, win_col=c, win_dir=d, draw=0;
  - go to DONE.
- When nothing qualifies:
  - accumulate an "any empty" flag from cell idx;
  - if idx = N*N−1, register winner=0, winner_player=00, win_row/col/dir=0, draw = !any_empty, and go to DONE;
  - otherwise idx+1.
- DONE:
  - done=1 for exactly one cycle, busy=0, then IDLE.
  - start asserted in DONE is ignored.
- Changes to `board` after capture have no effect on the scan in progress.
- A board where both players have runs is not flagged; the first run in scan order is reported.

## Timing
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, winner=0, winner_player=00, draw=0, win_row=0, win_col=0, win_dir=00, idx=0, snapshot=0.
- Start accepted in cycle 0:
  - busy=1 in cycles 1..(completion).
  - Cell i is evaluated in cycle i+1.
  - A win at cell i gives done=1 in cycle i+2; results are valid in that same cycle and held afterwards.
  - No win gives done in cycle N*N+1.
- Worst-case latency is N*N+1 cycles; the next start is accepted one cycle after done.
- Reset asserted mid-SCAN aborts immediately to the reset values; no done pulse is produced.
- start while busy=1 is ignored, with no queuing.

## Test plan
- N=3, K=3; cells 3,4,5 = 01, others 00; start at cycle 0 → done in cycle 5, winner=1, winner_player=01, win_row=1, win_col=0, win_dir=00, draw=0, busy high in cycles 1–4.
- N=3, K=3; cells 2,4,6 = 10, cells 0,1 = 01 → done in cycle 4, winner_player=10, win_row=0, win_col=2, win_dir=11.
- N=3, K=3; full board 01,10,01 / 01,10,10 / 10,01,01 (no line) → done in cycle 10, winner=0, winner_player=00, draw=1. The same board with cell 8 = 11 → draw=0.
- N=5, K=4; cells (0,0),(0,1),(0,2),(0,3) = 01 and (0,0),(1,0),(2,0),(3,0) = 01 → done in cycle 2, win_dir=00 (priority). Second run with only the column → win_dir=01.
- N=3; start, then a second start at cycle 3 and a board change at cycle 2 → the second start and the board change are ignored, exactly one done, results from the captured board.
- rst_n pulsed low in cycle 4 of a scan → all outputs at reset values immediately, no done. A fresh start after release evaluates normally.
